adjust_button_control: RTL and testbench



---
 rtl/clock_adjust_pkg.sv | 34 +++
 rtl/adjust_button_control_debouncer.sv | 62 ++++++
 rtl/adjust_button_control.sv | 109 ++++++++++
 tb/tb_adjust_button_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_adjust_pkg.sv
// Shared constants and mode type for the time-adjust path.
// The ADJ_* encodings are also used by adjust_inc_control downstream.
package clock_adjust_pkg;

   localparam int unsigned ADJ_MODE_W = 3;

   localparam logic [ADJ_MODE_W-1:0] ADJ_NORMAL  = 3'b000;
   localparam logic [ADJ_MODE_W-1:0] ADJ_HOURS   = 3'b100;
   localparam logic [ADJ_MODE_W-1:0] ADJ_MINUTES = 3'b010;
   localparam logic [ADJ_MODE_W-1:0] ADJ_SECONDS = 3'b001;

   // The state encoding is the output encoding, so adjust_mode is the state register.
   typedef enum logic [ADJ_MODE_W-1:0] {
      MODE_NORMAL  = ADJ_NORMAL,
      MODE_HOURS   = ADJ_HOURS,
      MODE_MINUTES = ADJ_MINUTES,
      MODE_SECONDS = ADJ_SECONDS
   } adj_mode_e;

   // Next field in the NORMAL -> HOURS -> MINUTES -> SECONDS -> NORMAL cycle.
   // Any unexpected encoding falls back to NORMAL.
   function automatic adj_mode_e adj_mode_advance(input adj_mode_e cur);
      adj_mode_e nxt;
      case (cur)
         MODE_NORMAL:  nxt = MODE_HOURS;
         MODE_HOURS:   nxt = MODE_MINUTES;
         MODE_MINUTES: nxt = MODE_SECONDS;
         MODE_SECONDS: nxt = MODE_NORMAL;
         default:      nxt = MODE_NORMAL;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/adjust_button_control_debouncer.sv
// button_debouncer: 2-flop synchroniser plus counter debounce for one raw button.
// level is the accepted (stable) level; press is a one-cycle pulse on each
// accepted rising level. Releases produce no pulse.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stb;
   logic             stb_q;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Accept a new level only after it has differed from stb for DEBOUNCE_CYCLES
   // consecutive cycles; any return to the old level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb <= 1'b0;
         cnt <= '0;
      end else if (s2 == stb) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stb <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Delayed copy of the stable level for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_q <= 1'b0;
      end else begin
         stb_q <= stb;
      end
   end

   assign level = stb;
   assign press = stb & ~stb_q;

endmodule

// File: rtl/adjust_button_control.sv
// adjust_button_control: conditions the mode and increment buttons and runs
// the adjust-mode state machine feeding adjust_inc_control.
// Optional feature: define ADJUST_TIMEOUT_EN to return to NORMAL after
// TIMEOUT_CYCLES idle cycles in an adjust field.
module adjust_button_control
   import clock_adjust_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_button_raw,
   input  logic                  inc_button_raw,
   output logic [ADJ_MODE_W-1:0] adjust_mode,
   output logic                  adjust_increment
);

   logic      mode_level;
   logic      mode_press;
   logic      inc_level;
   logic      inc_press;
   logic      timeout_fire;
   adj_mode_e mode_q;
   adj_mode_e mode_next;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("adjust_button_control: TIMEOUT_CYCLES must be >= 2");
   end

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (mode_button_raw),
      .level (mode_level),
      .press (mode_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_inc_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (inc_button_raw),
      .level (inc_level),
      .press (inc_press)
   );

   // Increment is level-driven; its press pulse has no consumer here.
   logic unused_inc_press;
   assign unused_inc_press = inc_press;

`ifdef ADJUST_TIMEOUT_EN
   localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] tmr;

   // Idle timer: counts only while in an adjust field with both buttons released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr <= '0;
      end else if (mode_press || timeout_fire || (mode_q == MODE_NORMAL) ||
                   mode_level || inc_level) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 1'b1;
      end
   end

   assign timeout_fire = (tmr == TMR_LAST);
`else
   assign timeout_fire = 1'b0;

   logic unused_mode_level;
   assign unused_mode_level = mode_level;
`endif

   // Next mode: a press advances (and beats a simultaneous timeout); illegal
   // encodings recover to NORMAL.
   always_comb begin
      case (mode_q)
         MODE_NORMAL, MODE_HOURS, MODE_MINUTES, MODE_SECONDS: mode_next = mode_q;
         default:                                             mode_next = MODE_NORMAL;
      endcase
      if (mode_press) begin
         mode_next = adj_mode_advance(mode_q);
      end else if (timeout_fire) begin
         mode_next = MODE_NORMAL;
      end
   end

   // Mode FSM and registered increment; increment uses the mode written on the
   // same edge so it drops together with a wrap to NORMAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q           <= MODE_NORMAL;
         adjust_increment <= 1'b0;
      end else begin
         mode_q           <= mode_next;
         adjust_increment <= inc_level && (mode_next != MODE_NORMAL);
      end
   end

   assign adjust_mode = mode_q;

endmodule

// File: tb/tb_adjust_button_control.sv
// Self-checking bench for adjust_button_control (DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=20). Expected outputs are queued with the cycle they are due
// and compared at the following falling edge.
module tb_adjust_button_control;

   localparam int unsigned DB = 4;
   localparam int unsigned TO = 20;
   localparam int unsigned LAT = DB + 3;  // drive cycle -> output change cycle

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_button_raw;
   logic       inc_button_raw;
   logic [2:0] adjust_mode;
   logic       adjust_increment;

   adjust_button_control #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .mode_button_raw  (mode_button_raw),
      .inc_button_raw   (inc_button_raw),
      .adjust_mode      (adjust_mode),
      .adjust_increment (adjust_increment)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [2:0]  mode;
      logic        inc;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_mode;
   logic       exp_inc;
   logic       inc_lvl;

   function automatic logic [2:0] model_next(input logic [2:0] m);
      case (m)
         3'b000:  return 3'b100;
         3'b100:  return 3'b010;
         3'b010:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [2:0] em, input logic ei);
      checks++;
      assert ({adjust_mode, adjust_increment} === {em, ei}) else begin
         errors++;
         $error("FAIL %s @cyc %0d: got mode=%b inc=%b, expected mode=%b inc=%b",
                tag, cyc, adjust_mode, adjust_increment, em, ei);
      end
   endtask

   task automatic expect_at(input int unsigned c, input logic [2:0] m, input logic i,
                            input string tag);
      exp_t e;
      e.cyc  = c;
      e.mode = m;
      e.inc  = i;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   // Advance n falling edges, retiring every scoreboard entry that is due.
   task automatic tick(input int unsigned n);
      exp_t e;
      repeat (n) begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check(e.tag, e.mode, e.inc);
         end
      end
   endtask

   task automatic mode_down(input string tag);
      int unsigned n;
      n = cyc;
      expect_at(n + LAT - 1, exp_mode, exp_inc, {tag, "_pre"});
      exp_mode = model_next(exp_mode);
      exp_inc  = inc_lvl && (exp_mode != 3'b000);
      expect_at(n + LAT, exp_mode, exp_inc, tag);
      mode_button_raw = 1'b1;
   endtask

   task automatic mode_up(input string tag);
      expect_at(cyc + LAT, exp_mode, exp_inc, tag);
      mode_button_raw = 1'b0;
   endtask

   task automatic inc_down(input string tag);
      int unsigned n;
      n = cyc;
      expect_at(n + LAT - 1, exp_mode, exp_inc, {tag, "_pre"});
      inc_lvl = 1'b1;
      exp_inc = (exp_mode != 3'b000);
      expect_at(n + LAT, exp_mode, exp_inc, tag);
      inc_button_raw = 1'b1;
   endtask

   task automatic inc_up(input string tag);
      int unsigned n;
      n = cyc;
      expect_at(n + LAT - 1, exp_mode, exp_inc, {tag, "_pre"});
      inc_lvl = 1'b0;
      exp_inc = 1'b0;
      expect_at(n + LAT, exp_mode, exp_inc, tag);
      inc_button_raw = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      int unsigned r;
      int unsigned p;
      int unsigned q;

      rst             = 1'b1;
      mode_button_raw = 1'b0;
      inc_button_raw  = 1'b0;
      exp_mode        = 3'b000;
      exp_inc         = 1'b0;
      inc_lvl         = 1'b0;

      // Reset state
      tick(3);
      check("reset", 3'b000, 1'b0);
      rst = 1'b0;

      // Idle after reset
      for (int k = 1; k <= 10; k++) expect_at(cyc + k, 3'b000, 1'b0, "idle");
      tick(10);

      // Four clean presses: 100, 010, 001, 000
      for (int k = 0; k < 4; k++) begin
         mode_down("clean_press");
         tick(8);
         mode_up("clean_release");
         tick(8);
      end

      // Short bursts alone never change the mode
      n = cyc;
      for (int k = 1; k <= 20; k++) expect_at(n + k, 3'b000, 1'b0, "burst_nochange");
      mode_button_raw = 1'b1; tick(3);
      mode_button_raw = 1'b0; tick(4);
      mode_button_raw = 1'b1; tick(2);
      mode_button_raw = 1'b0; tick(3);
      mode_button_raw = 1'b1; tick(1);
      mode_button_raw = 1'b0; tick(7);

      // Bounce then settle high: single advance to HOURS
      mode_button_raw = 1'b1; tick(2);
      mode_button_raw = 1'b0; tick(1);
      mode_button_raw = 1'b1; tick(3);
      mode_button_raw = 1'b0; tick(2);
      mode_down("bounce_settle");
      tick(12);
      mode_up("bounce_release");
      tick(8);

      // MINUTES, increment held 12 cycles
      mode_down("to_minutes");
      tick(8);
      mode_up("minutes_release");
      tick(8);
      inc_down("inc_rise");
      tick(12);
      inc_up("inc_fall");
      tick(8);

      // Increment carries into SECONDS, drops on wrap to NORMAL
      inc_down("inc_hold");
      tick(8);
      mode_down("to_seconds_inc_held");
      tick(8);
      mode_up("seconds_release");
      tick(8);
      mode_down("wrap_drops_inc");
      tick(8);
      mode_up("normal_release");
      tick(8);
      inc_up("inc_release_normal");
      tick(8);

      // Increment in NORMAL stays low; entering HOURS raises it on the mode edge
      inc_down("inc_in_normal");
      tick(10);
      mode_down("enter_hours_inc_held");
      tick(8);

      // Asynchronous reset mid-hold, checked before the next clk edge
      #2 rst = 1'b1;
      #1 check("async_reset", 3'b000, 1'b0);
      exp_mode = 3'b000;
      exp_inc  = 1'b0;
      tick(2);

      // Buttons held through reset must debounce again, then advance
      n   = cyc;
      rst = 1'b0;
      expect_at(n + LAT - 1, 3'b000, 1'b0, "post_reset_pre");
      exp_mode = 3'b100;
      exp_inc  = 1'b1;
      expect_at(n + LAT, exp_mode, exp_inc, "post_reset_press");
      tick(10);

      // Release both; then the idle-timeout window
      n = cyc;
      inc_up("release_both");
      mode_button_raw = 1'b0;
`ifdef ADJUST_TIMEOUT_EN
      expect_at(n + LAT - 1 + TO - 1, exp_mode, 1'b0, "timeout_pre");
      exp_mode = 3'b000;
      expect_at(n + LAT - 1 + TO, exp_mode, 1'b0, "timeout_exit");
`else
      expect_at(n + LAT - 1 + TO, exp_mode, 1'b0, "no_timeout");
`endif
      tick(TO + 12);

      // Re-enter HOURS if needed, idle 10, then increment restarts the timer
      if (exp_mode == 3'b000) begin
         mode_down("reenter_hours");
         tick(8);
         mode_up("reenter_release");
      end
      r = cyc;
      tick(LAT - 1 + 10);
      p = cyc;
      inc_down("inc_restarts_timer");
      expect_at(r + LAT - 1 + TO, exp_mode, 1'b1, "no_exit_while_inc");
      tick(12);
      q = cyc;
      inc_up("inc_release_hours");
`ifdef ADJUST_TIMEOUT_EN
      expect_at(q + LAT - 1 + TO - 1, exp_mode, 1'b0, "timeout2_pre");
      exp_mode = 3'b000;
      expect_at(q + LAT - 1 + TO, exp_mode, 1'b0, "timeout2_exit");
`else
      expect_at(q + LAT - 1 + TO, exp_mode, 1'b0, "no_timeout2");
`endif
      tick(TO + 12);

      // Every queued expectation must have been retired
      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
